// File: rtl/cpu_monitor_pkg.sv
// Shared definitions for the CPU run-control / performance-monitor unit.
package cpu_monitor_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALT    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int DEF_PRINT_CODE = 34;
  localparam int DISP_PRINT     = 0;

endpackage

// File: rtl/evt_counter.sv
// Single event counter with wrap or saturate behaviour and a sticky overflow flag.
module evt_counter
  import cpu_monitor_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter bit SAT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic at_max;

  assign at_max = &count;

  // clr wins over a same-cycle increment; at all-ones SAT_MODE picks hold vs wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (at_max) begin
        ovf <= 1'b1;
        if (!SAT_MODE) count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_monitor.sv
// Run-control (syscall halt / go resume / print capture), event counters
// and registered display word for the MIPS cores.
module cpu_monitor
  import cpu_monitor_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int N_EVT      = 4,
  parameter int SEL_W      = 3,
  parameter bit SAT_MODE   = 1'b0,
  parameter int PRINT_CODE = DEF_PRINT_CODE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step_en,
  input  logic                   syscall,
  input  logic [31:0]            v0_data,
  input  logic [31:0]            a0_data,
  input  logic                   go,
  input  logic [N_EVT-1:0]       evt,
  input  logic                   clr_cnt,
  input  logic [SEL_W-1:0]       disp_sel,
  output logic                   pc_en,
  output logic                   halted,
  output logic [31:0]            print_data,
  output logic                   print_valid,
  output logic [N_EVT*CNT_W-1:0] cnt_flat,
  output logic [N_EVT-1:0]       ovf,
  output logic [31:0]            disp_data
);

  state_t state, state_next;
  logic   go_meta, go_sync, go_prev, go_rise;
  logic   is_print, halt_req, print_fire;
  logic [31:0] disp_next;

  // go is asynchronous: two-flop synchroniser, then a rising-edge detector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_meta <= 1'b0;
      go_sync <= 1'b0;
      go_prev <= 1'b0;
    end else begin
      go_meta <= go;
      go_sync <= go_meta;
      go_prev <= go_sync;
    end
  end

  assign go_rise  = go_sync & ~go_prev;
  assign is_print = syscall & (v0_data == 32'(PRINT_CODE));
  assign halt_req = syscall & ~is_print;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // go_rise only matters in HALT, so edges seen in RUN/RELEASE are simply dropped
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (step_en && halt_req) state_next = HALT;
      HALT:    if (go_rise)             state_next = RELEASE;
      RELEASE: if (step_en)             state_next = RUN;
      default:                          state_next = RUN;
    endcase
  end

  always_comb begin
    pc_en      = 1'b0;
    halted     = 1'b0;
    print_fire = 1'b0;
    case (state)
      RUN: begin
        pc_en      = step_en & ~halt_req;
        print_fire = step_en & is_print;
      end
      HALT:    halted = 1'b1;
      RELEASE: pc_en  = step_en;
      default: pc_en  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      print_data  <= '0;
      print_valid <= 1'b0;
    end else begin
      print_valid <= print_fire;
      if (print_fire) print_data <= a0_data;
    end
  end

  for (genvar k = 0; k < N_EVT; k++) begin : g_cnt
    evt_counter #(
      .CNT_W    (CNT_W),
      .SAT_MODE (SAT_MODE)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (step_en & evt[k]),
      .clr   (clr_cnt),
      .count (cnt_flat[k*CNT_W +: CNT_W]),
      .ovf   (ovf[k])
    );
  end

  // select 0 shows the print word, 1..N_EVT a zero-extended counter, anything else 0
  always_comb begin
    disp_next = '0;
    if (disp_sel == SEL_W'(DISP_PRINT)) begin
      disp_next = print_data;
    end else begin
      for (int k = 0; k < N_EVT; k++) begin
        if (disp_sel == SEL_W'(k + 1)) disp_next[CNT_W-1:0] = cnt_flat[k*CNT_W +: CNT_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) disp_data <= '0;
    else     disp_data <= disp_next;
  end

endmodule

// File: tb/tb_cpu_monitor.sv
// Directed bench for cpu_monitor: two 4-bit-counter instances (wrap and saturate)
// driven by the same stimulus.
module tb_cpu_monitor;

  localparam int CNT_W = 4;
  localparam int N_EVT = 4;
  localparam int SEL_W = 3;

  logic clk = 1'b0;
  logic rst, step_en, syscall, go, clr_cnt;
  logic [31:0] v0_data, a0_data;
  logic [N_EVT-1:0] evt;
  logic [SEL_W-1:0] disp_sel;

  logic pc_en_w, halted_w, pv_w, pc_en_s, halted_s, pv_s;
  logic [31:0] pd_w, disp_w, pd_s, disp_s;
  logic [N_EVT*CNT_W-1:0] cnt_w, cnt_s;
  logic [N_EVT-1:0] ovf_w, ovf_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_monitor #(.CNT_W(CNT_W), .N_EVT(N_EVT), .SEL_W(SEL_W), .SAT_MODE(1'b0), .PRINT_CODE(34)) u_wrap (
    .clk(clk), .rst(rst), .step_en(step_en), .syscall(syscall), .v0_data(v0_data),
    .a0_data(a0_data), .go(go), .evt(evt), .clr_cnt(clr_cnt), .disp_sel(disp_sel),
    .pc_en(pc_en_w), .halted(halted_w), .print_data(pd_w), .print_valid(pv_w),
    .cnt_flat(cnt_w), .ovf(ovf_w), .disp_data(disp_w));

  cpu_monitor #(.CNT_W(CNT_W), .N_EVT(N_EVT), .SEL_W(SEL_W), .SAT_MODE(1'b1), .PRINT_CODE(34)) u_sat (
    .clk(clk), .rst(rst), .step_en(step_en), .syscall(syscall), .v0_data(v0_data),
    .a0_data(a0_data), .go(go), .evt(evt), .clr_cnt(clr_cnt), .disp_sel(disp_sel),
    .pc_en(pc_en_s), .halted(halted_s), .print_data(pd_s), .print_valid(pv_s),
    .cnt_flat(cnt_s), .ovf(ovf_s), .disp_data(disp_s));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h want=0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_unhalt(input string tag);
    int n;
    n = 0;
    while (halted_w && n < 12) begin
      tick();
      n++;
    end
    check(tag, 32'(halted_w), 32'd0);
  endtask

  initial begin
    rst = 1'b1; step_en = 1'b0; syscall = 1'b0; go = 1'b0; clr_cnt = 1'b0;
    v0_data = '0; a0_data = '0; evt = '0; disp_sel = '0;
    tick(); tick();
    rst = 1'b0;

    // 1: plain running after reset
    step_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("run_pc_en", 32'(pc_en_w), 32'd1);
      tick();
    end
    check("rst_halted", 32'(halted_w), 32'd0);
    check("rst_cnt", 32'(cnt_w), 32'd0);
    check("rst_ovf", 32'(ovf_w), 32'd0);
    check("rst_disp", disp_w, 32'd0);

    // 2: print syscall
    syscall = 1'b1; v0_data = 32'd34; a0_data = 32'h1234_5678;
    #1 check("print_pc_en", 32'(pc_en_w), 32'd1);
    tick();
    syscall = 1'b0;
    check("print_valid_hi", 32'(pv_w), 32'd1);
    check("print_data", pd_w, 32'h1234_5678);
    check("print_no_halt", 32'(halted_w), 32'd0);
    tick();
    check("print_valid_lo", 32'(pv_w), 32'd0);
    check("print_disp", disp_w, 32'h1234_5678);

    // 3: halting syscall, ignored steps, go resume
    syscall = 1'b1; v0_data = 32'd10;
    #1 check("halt_pc_en", 32'(pc_en_w), 32'd0);
    tick();
    check("halt_halted", 32'(halted_w), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step_en = 1'b1;
      #1 check("halt_step_pc_en", 32'(pc_en_w), 32'd0);
      tick();
      step_en = 1'b0;
      tick();
    end
    check("halt_still", 32'(halted_w), 32'd1);
    go = 1'b1;
    tick(); tick(); tick();
    go = 1'b0;
    wait_unhalt("go_release");
    check("release_idle_pc_en", 32'(pc_en_w), 32'd0);
    step_en = 1'b1;
    #1 check("release_pc_en", 32'(pc_en_w), 32'd1);
    tick();
    syscall = 1'b0;
    #1 check("back_run_pc_en", 32'(pc_en_w), 32'd1);
    check("back_run_halted", 32'(halted_w), 32'd0);

    // 4: 17 increments on channel 0, wrap vs saturate
    evt = 4'b0001;
    for (int i = 0; i < 17; i++) tick();
    evt = '0;
    check("wrap_cnt0", 32'(cnt_w[3:0]), 32'd1);
    check("wrap_ovf0", 32'(ovf_w[0]), 32'd1);
    check("sat_cnt0", 32'(cnt_s[3:0]), 32'd15);
    check("sat_ovf0", 32'(ovf_s[0]), 32'd1);
    check("wrap_ovf_others", 32'(ovf_w[3:1]), 32'd0);
    disp_sel = 3'd1;
    tick();
    check("sat_disp1", disp_s, 32'h0000_000F);
    check("wrap_disp1", disp_w, 32'h0000_0001);
    disp_sel = 3'd5;
    tick();
    check("disp_out_of_range", disp_s, 32'd0);

    // counters only move on step_en
    step_en = 1'b0; evt = 4'b0001;
    tick(); tick();
    check("no_step_cnt0", 32'(cnt_w[3:0]), 32'd1);
    step_en = 1'b1;

    // 5: channel 1 to 5, then clr_cnt beats a same-cycle increment
    evt = 4'b0010;
    for (int i = 0; i < 5; i++) tick();
    check("cnt1_five", 32'(cnt_w[7:4]), 32'd5);
    disp_sel = 3'd2;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0; evt = '0;
    check("clr_cnt1", 32'(cnt_w[7:4]), 32'd0);
    check("clr_ovf", 32'(ovf_w), 32'd0);
    check("clr_sat_all", 32'(cnt_s), 32'd0);
    check("disp_cnt1_before_clr", disp_w, 32'd5);

    // 6a: go held high across the halt must not resume it
    go = 1'b1;
    tick(); tick(); tick(); tick();
    syscall = 1'b1; v0_data = 32'd10;
    tick();
    step_en = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("held_go_halted", 32'(halted_w), 32'd1);
    go = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("go_fall_halted", 32'(halted_w), 32'd1);
    go = 1'b1;
    wait_unhalt("go_reedge_release");
    go = 1'b0;
    step_en = 1'b1;
    tick();
    syscall = 1'b0;
    #1 check("after_release_pc_en", 32'(pc_en_w), 32'd1);

    // 6b: async reset while halted
    syscall = 1'b1; v0_data = 32'd10;
    tick();
    syscall = 1'b0;
    check("halt2_halted", 32'(halted_w), 32'd1);
    rst = 1'b1;
    #2;
    check("rst_in_halt_halted", 32'(halted_w), 32'd0);
    check("rst_in_halt_print", pd_w, 32'd0);
    tick();
    rst = 1'b0;
    #1 check("rst_in_halt_pc_en", 32'(pc_en_w), 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
